// File: rtl/processor_n.sv
// rtl/processor_n.sv - N-bit multicycle processor, R7 = PC, single-port synchronous memory.
// Define PROC_AND_EN to make opcode 110 an and; otherwise it executes as a NOP.
module processor_n #(
   parameter int N = 16
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         Run,
   input  logic [N-1:0] DIN,
   output logic         Done,
   output logic [N-1:0] ADDR,
   output logic [N-1:0] DOUT,
   output logic         W
);

`ifdef PROC_AND_EN
   localparam logic AND_EN = 1'b1;
`else
   localparam logic AND_EN = 1'b0;
`endif

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVT = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_LD  = 3'b100;
   localparam logic [2:0] OP_ST  = 3'b101;
   localparam logic [2:0] OP_AND = 3'b110;
   localparam logic [2:0] OP_B   = 3'b111;

   typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} state_t;

   state_t       state, state_nxt;
   logic [N-1:0] r [0:7];
   logic [N-1:0] a, g, ir;
   logic         z, n, c;

   logic [2:0]   op, x, y;
   logic         m;
   logic [N-8:0] d;
   logic [N-1:0] op2, sext, alu_res;
   logic         alu_c, is_alu, short_op, cond, final_step;

   assign op   = ir[N-1:N-3];
   assign m    = ir[N-4];
   assign x    = ir[N-5:N-7];
   assign d    = ir[N-8:0];
   assign y    = ir[2:0];
   assign op2  = m ? {7'b0, d} : r[y];
   assign sext = {{7{d[N-8]}}, d};

   assign is_alu   = (op == OP_ADD) || (op == OP_SUB) || ((op == OP_AND) && AND_EN);
   assign short_op = (op == OP_MV) || (op == OP_MVT) || (op == OP_ST) ||
                     ((op == OP_AND) && !AND_EN);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (op)
         OP_ADD:  {alu_c, alu_res} = {1'b0, a} + {1'b0, op2};
         OP_SUB:  begin
            alu_res = a - op2;
            alu_c   = (a < op2);
         end
         OP_AND:  alu_res = a & op2;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      case (x)
         3'd0:    cond = 1'b1;
         3'd1:    cond = z;
         3'd2:    cond = !z;
         3'd3:    cond = !c;
         3'd4:    cond = c;
         3'd5:    cond = !n;
         3'd6:    cond = n;
         default: cond = 1'b0;
      endcase
   end

   // A stalled final step is not final: Done and the state advance both wait for Run.
   always_comb begin
      state_nxt  = state;
      final_step = 1'b0;
      case (state)
         T0: state_nxt = T1;
         T1: state_nxt = T2;
         T2: state_nxt = T3;
         T3: begin
            if (short_op) begin
               final_step = 1'b1;
               state_nxt  = T0;
            end else begin
               state_nxt  = T4;
            end
         end
         T4: state_nxt = T5;
         T5: begin
            final_step = 1'b1;
            state_nxt  = T0;
         end
         default: state_nxt = T0;
      endcase
      if (!Run) state_nxt = state;
   end

   assign Done = final_step & Run;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= T0;
         for (int i = 0; i < 8; i++) r[i] <= '0;
         a    <= '0;
         g    <= '0;
         ir   <= '0;
         z    <= 1'b0;
         n    <= 1'b0;
         c    <= 1'b0;
         ADDR <= '0;
         DOUT <= '0;
         W    <= 1'b0;
      end else begin
         // The store strobe is a one-cycle pulse regardless of Run.
         W     <= 1'b0;
         state <= state_nxt;
         if (Run) begin
            case (state)
               T0: begin
                  ADDR <= r[7];
                  r[7] <= r[7] + N'(1);
               end
               T2: ir <= DIN;
               T3: begin
                  case (op)
                     OP_MV:  r[x] <= op2;
                     OP_MVT: r[x] <= {ir[N/2-1:0], {(N/2){1'b0}}};
                     OP_LD:  ADDR <= r[y];
                     OP_ST: begin
                        ADDR <= r[y];
                        DOUT <= r[x];
                        W    <= 1'b1;
                     end
                     OP_B:   a <= r[7];
                     default: if (is_alu) a <= r[x];
                  endcase
               end
               T4: begin
                  if (op == OP_B) begin
                     g <= a + sext;
                  end else if (is_alu) begin
                     g <= alu_res;
                     z <= (alu_res == '0);
                     n <= alu_res[N-1];
                     c <= alu_c;
                  end
               end
               T5: begin
                  if (op == OP_B) begin
                     if (cond) r[7] <= g;
                  end else if (op == OP_LD) begin
                     r[x] <= DIN;
                  end else if (is_alu) begin
                     r[x] <= g;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
